led_breathe: RTL and testbench

- LED output stage; sits directly downstream of the board clock selection (HPS user clock or external mezzanine clock).
- Replaces the fixed blinker with a PWM "breathing" driver for the two RF-board LEDs.
- The duty ramps up and down continuously through a state machine.
- LED2 is always the exact complement of LED1 while enabled.

---
 rtl/led_breathe.sv | 147 ++++++++++++++
 tb/tb_led_breathe.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_breathe.sv
// PWM "breathing" driver for the two RF-board LEDs: duty ramps up, holds,
// ramps down, holds, and repeats; led2 is the complement of led1 while running.
module led_breathe #(
  parameter int unsigned PRESCALE     = 390,
  parameter int unsigned PWM_BITS     = 8,
  parameter int unsigned STEP_PERIODS = 4,
  parameter int unsigned HOLD_STEPS   = 64
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  output logic                led1,
  output logic                led2,
  output logic [PWM_BITS-1:0] duty,
  output logic                cycle_done
);

  localparam int unsigned PRE_W  = (PRESCALE > 1)     ? $clog2(PRESCALE)     : 1;
  localparam int unsigned STEP_W = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
  localparam int unsigned HOLD_W = (HOLD_STEPS > 1)   ? $clog2(HOLD_STEPS)   : 1;

  localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(PRESCALE - 1);
  localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEP_PERIODS - 1);
  localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD_STEPS - 1);
  localparam logic [PWM_BITS-1:0] MAX       = '1;

  typedef enum logic [2:0] {
    S_OFF,
    S_UP,
    S_HOLD_HI,
    S_DOWN,
    S_HOLD_LO
  } state_e;

  state_e              state_q, state_d;
  logic [PRE_W-1:0]    pre_q,   pre_d;
  logic [PWM_BITS-1:0] pwm_q,   pwm_d;
  logic [STEP_W-1:0]   stp_q,   stp_d;
  logic [HOLD_W-1:0]   hold_q,  hold_d;
  logic [PWM_BITS-1:0] duty_q,  duty_d;
  logic                led1_q,  led1_d;
  logic                led2_q,  led2_d;
  logic                cdone_q, cdone_d;

  logic tick, period_end, step, lit;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_OFF;
      pre_q   <= '0;
      pwm_q   <= '0;
      stp_q   <= '0;
      hold_q  <= '0;
      duty_q  <= '0;
      led1_q  <= 1'b0;
      led2_q  <= 1'b0;
      cdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      pwm_q   <= pwm_d;
      stp_q   <= stp_d;
      hold_q  <= hold_d;
      duty_q  <= duty_d;
      led1_q  <= led1_d;
      led2_q  <= led2_d;
      cdone_q <= cdone_d;
    end
  end

  always_comb begin
    tick       = (pre_q == PRE_LAST);
    period_end = tick && (pwm_q == MAX);
    step       = period_end && (stp_q == STEP_LAST);
    lit        = (pwm_q < duty_q);

    state_d = state_q;
    pre_d   = pre_q;
    pwm_d   = pwm_q;
    stp_d   = stp_q;
    hold_d  = hold_q;
    duty_d  = duty_q;
    led1_d  = 1'b0;
    led2_d  = 1'b0;
    cdone_d = 1'b0;

    // enable low wins over any pending step: immediate stop, no fade-out
    if (!enable || state_q == S_OFF) begin
      state_d = enable ? S_UP : S_OFF;
      pre_d   = '0;
      pwm_d   = '0;
      stp_d   = '0;
      hold_d  = '0;
      duty_d  = '0;
    end else begin
      led1_d = lit;
      led2_d = !lit;
      pre_d  = tick ? '0 : pre_q + 1'b1;
      if (tick)       pwm_d = pwm_q + 1'b1;
      if (period_end) stp_d = step ? '0 : stp_q + 1'b1;
      if (step) begin
        case (state_q)
          S_UP: begin
            if (duty_q == MAX) begin
              state_d = S_HOLD_HI;
              hold_d  = '0;
            end else begin
              duty_d = duty_q + 1'b1;
            end
          end
          S_HOLD_HI: begin
            if (hold_q == HOLD_LAST) begin
              state_d = S_DOWN;
              hold_d  = '0;
            end else begin
              hold_d = hold_q + 1'b1;
            end
          end
          S_DOWN: begin
            if (duty_q == '0) begin
              state_d = S_HOLD_LO;
              hold_d  = '0;
            end else begin
              duty_d = duty_q - 1'b1;
            end
          end
          S_HOLD_LO: begin
            if (hold_q == HOLD_LAST) begin
              state_d = S_UP;
              hold_d  = '0;
              cdone_d = 1'b1;
            end else begin
              hold_d = hold_q + 1'b1;
            end
          end
          default: state_d = S_OFF;
        endcase
      end
    end
  end

  assign led1       = led1_q;
  assign led2       = led2_q;
  assign duty       = duty_q;
  assign cycle_done = cdone_q;

endmodule

// File: tb/tb_led_breathe.sv
// Bench for led_breathe: vector table, directed corner sequences and random
// enable/reset traffic, all checked every cycle against a time-based envelope model.
module tb_led_breathe;

  localparam int PRESCALE     = 2;
  localparam int PWM_BITS     = 3;
  localparam int STEP_PERIODS = 1;
  localparam int HOLD_STEPS   = 2;
  localparam int MAXV         = (1 << PWM_BITS) - 1;
  localparam int STEP_CLKS    = STEP_PERIODS * PRESCALE * (MAXV + 1);
  localparam int CYC_STEPS    = 2 * (MAXV + 1) + 2 * HOLD_STEPS;
  localparam int CYC_CLKS     = STEP_CLKS * CYC_STEPS;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                enable;
  logic                led1;
  logic                led2;
  logic [PWM_BITS-1:0] duty;
  logic                cycle_done;

  int tests = 0;
  int fails = 0;
  bit m_on  = 1'b0;
  int m_t   = 0;

  typedef struct {
    bit rst_n;
    bit en;
    int ncyc;
    int duty;
    bit l1;
    bit l2;
    bit cd;
  } vec_t;

  vec_t vecs[9];

  led_breathe #(
    .PRESCALE    (PRESCALE),
    .PWM_BITS    (PWM_BITS),
    .STEP_PERIODS(STEP_PERIODS),
    .HOLD_STEPS  (HOLD_STEPS)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .led1      (led1),
    .led2      (led2),
    .duty      (duty),
    .cycle_done(cycle_done)
  );

  always #5 clk = ~clk;

  // Envelope as a function of clocks since the ramp started (t=0 on the OFF->UP edge).
  function automatic int f_duty(input int t);
    int p;
    p = (t / STEP_CLKS) % CYC_STEPS;
    if (p <= MAXV) return p;
    if (p <= MAXV + 1 + HOLD_STEPS) return MAXV;
    if (p <= 2 * MAXV + HOLD_STEPS + 1) return 2 * MAXV + HOLD_STEPS + 1 - p;
    return 0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick_chk();
    int  e_duty;
    bit  e_l1, e_l2, e_cd, on_run;
    @(posedge clk);
    if (!reset_n || !enable) begin
      m_on = 1'b0;
    end else if (!m_on) begin
      m_on = 1'b1;
      m_t  = 0;
    end else begin
      m_t++;
    end
    @(negedge clk);
    on_run = m_on && (m_t >= 1);
    e_duty = m_on ? f_duty(m_t) : 0;
    e_l1   = on_run && ((((m_t - 1) / PRESCALE) % (MAXV + 1)) < f_duty(m_t - 1));
    e_l2   = on_run && !e_l1;
    e_cd   = m_on && (m_t > 0) && ((m_t % CYC_CLKS) == 0);
    chk($sformatf("model duty t=%0d", m_t), 32'(duty), 32'(e_duty));
    chk($sformatf("model led1 t=%0d", m_t), 32'(led1), 32'(e_l1));
    chk($sformatf("model led2 t=%0d", m_t), 32'(led2), 32'(e_l2));
    chk($sformatf("model cycle_done t=%0d", m_t), 32'(cycle_done), 32'(e_cd));
  endtask

  task automatic wait_duty(input int v, input int lim, input string nm);
    int n;
    n = 0;
    while (32'(duty) !== v && n < lim) begin
      tick_chk();
      n++;
    end
    chk(nm, 32'(duty), v);
  endtask

  initial begin
    int n, h1, h2, eq, cds, first1, r;

    reset_n = 1'b0;
    enable  = 1'b1;

    vecs[0] = '{1'b0, 1'b1, 3,   0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1,   0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 1,   0, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 15,  1, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 2,   1, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 302, 0, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{1'b1, 1'b1, 1,   0, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 1,   0, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 1'b1, 1,   0, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 9; i++) begin
      reset_n = vecs[i].rst_n;
      enable  = vecs[i].en;
      for (int c = 0; c < vecs[i].ncyc; c++) tick_chk();
      chk($sformatf("vec%0d duty", i), 32'(duty), vecs[i].duty);
      chk($sformatf("vec%0d led1", i), 32'(led1), 32'(vecs[i].l1));
      chk($sformatf("vec%0d led2", i), 32'(led2), 32'(vecs[i].l2));
      chk($sformatf("vec%0d cycle_done", i), 32'(cycle_done), 32'(vecs[i].cd));
    end

    // One PWM period at duty=3
    wait_duty(3, 200, "pwm reach duty3");
    h1 = 0; h2 = 0; eq = 0;
    for (int c = 0; c < STEP_CLKS; c++) begin
      tick_chk();
      h1 += int'(led1);
      h2 += int'(led2);
      if (led1 === led2) eq++;
    end
    chk("pwm led1 high clks", h1, 6);
    chk("pwm led2 high clks", h2, 10);
    chk("pwm led1==led2 clks", eq, 0);

    // Cycle_done spacing from a fresh enable
    enable = 1'b0;
    tick_chk();
    tick_chk();
    enable = 1'b1;
    tick_chk();
    n = 0;
    do begin
      tick_chk();
      n++;
    end while (cycle_done !== 1'b1 && n < 400);
    chk("cycle_done first gap", n, CYC_CLKS);
    tick_chk();
    chk("cycle_done width", 32'(cycle_done), 0);
    n = 1;
    do begin
      tick_chk();
      n++;
    end while (cycle_done !== 1'b1 && n < 400);
    chk("cycle_done second gap", n, CYC_CLKS);

    // Disable mid-DOWN at duty=4, then re-enable
    wait_duty(MAXV, 400, "down reach max");
    wait_duty(4, 400, "down reach duty4");
    enable = 1'b0;
    tick_chk();
    chk("disable duty", 32'(duty), 0);
    chk("disable led1", 32'(led1), 0);
    chk("disable led2", 32'(led2), 0);
    for (int c = 0; c < 4; c++) tick_chk();
    enable = 1'b1;
    tick_chk();
    n = 0;
    do begin
      tick_chk();
      n++;
    end while (32'(duty) !== 1 && n < 100);
    chk("reenable first duty1", n, STEP_CLKS);

    // Reset mid-HOLD_HI with enable held
    wait_duty(MAXV, 400, "hold reach max");
    for (int c = 0; c < 24; c++) tick_chk();
    reset_n = 1'b0;
    tick_chk();
    chk("reset duty", 32'(duty), 0);
    chk("reset led1", 32'(led1), 0);
    chk("reset led2", 32'(led2), 0);
    chk("reset cycle_done", 32'(cycle_done), 0);
    reset_n = 1'b1;
    tick_chk();
    chk("post-reset duty", 32'(duty), 0);
    cds = 0;
    first1 = -1;
    for (int c = 1; c <= 300; c++) begin
      tick_chk();
      if (cycle_done === 1'b1) cds++;
      if (32'(duty) === 1 && first1 < 0) first1 = c;
    end
    chk("post-reset cycle_done pulses", cds, 0);
    chk("post-reset first duty1", first1, STEP_CLKS);

    // Random enable toggles and reset pulses
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 999));
      reset_n = (r >= 3);
      if (r >= 992) enable = !enable;
      tick_chk();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
